// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID-stage hazard controller and its tracker.
package pipe_pkg;

  // Widest register number the tracker can hold. Narrower register fields are zero-extended.
  localparam int RN_MAX_W = 8;

  typedef logic [RN_MAX_W-1:0] rn_t;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EALU = 2'b01;
  localparam logic [1:0] FWD_MALU = 2'b10;
  localparam logic [1:0] FWD_MMEM = 2'b11;

  typedef struct packed {
    rn_t  rn;
    logic wreg;
    logic m2reg;
  } track_ent_t;

  // A source hazards against an in-flight entry only if it is read and nonzero,
  // and the entry actually writes that register.
  function automatic logic src_match(input rn_t src, input logic used, input track_ent_t ent);
    return used && (src != '0) && ent.wreg && (ent.rn == src);
  endfunction

endpackage

// File: rtl/pipe_dest_track.sv
// Three-entry destination tracker (EX, MEM, WB) with bubble insertion into EX.
module pipe_dest_track
  import pipe_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       bubble,
  input  track_ent_t id_ent,
  output track_ent_t ex_ent,
  output track_ent_t mem_ent,
  output track_ent_t wb_ent
);

  track_ent_t ex_q, mem_q, wb_q;
  track_ent_t ex_d, mem_d, wb_d;

  always_comb begin
    ex_d  = bubble ? '0 : id_ent;
    mem_d = ex_q;
    wb_d  = mem_q;
  end

  // NOTE: non-blocking assignments let all three stages shift off the same pre-edge values;
  // every entry is reset so no stale load can raise a hazard after reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_ent  = ex_q;
  assign mem_ent = mem_q;
  assign wb_ent  = wb_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard controller: load-use stall, operand forwarding selects, stall counter.
// Forwarding is compiled in only when PIPE_HAZARD_FWD_EN is defined; otherwise it stalls on any EX/MEM match.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NREG_BITS = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NREG_BITS-1:0] rs,
  input  logic [NREG_BITS-1:0] rt,
  input  logic                 use_rs,
  input  logic                 use_rt,
  input  logic [NREG_BITS-1:0] drn,
  input  logic                 dwreg,
  input  logic                 dm2reg,
  output logic                 wpcir,
  output logic [1:0]           fwda,
  output logic [1:0]           fwdb,
  output logic [CNT_W-1:0]     stall_cnt
);

  track_ent_t id_ent, ex_ent, mem_ent, wb_ent;
  rn_t        rs_w, rt_w;
  logic       ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic       unused_wb;

  assign rs_w   = RN_MAX_W'(rs);
  assign rt_w   = RN_MAX_W'(rt);
  assign id_ent = '{rn: RN_MAX_W'(drn), wreg: dwreg, m2reg: dm2reg};

  pipe_dest_track u_track (
    .clock   (clock),
    .resetn  (resetn),
    .bubble  (wpcir),
    .id_ent  (id_ent),
    .ex_ent  (ex_ent),
    .mem_ent (mem_ent),
    .wb_ent  (wb_ent)
  );

  // The register file writes before it is read, so a WB producer never needs a bypass.
  assign unused_wb = ^wb_ent;

  assign ex_hit_a  = src_match(rs_w, use_rs, ex_ent);
  assign ex_hit_b  = src_match(rt_w, use_rt, ex_ent);
  assign mem_hit_a = src_match(rs_w, use_rs, mem_ent);
  assign mem_hit_b = src_match(rt_w, use_rt, mem_ent);

`ifdef PIPE_HAZARD_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit && !ex_ent.m2reg) return FWD_EALU;
    if (mem_hit)                 return mem_ent.m2reg ? FWD_MMEM : FWD_MALU;
    return FWD_RF;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wpcir = 1'b0;
    fwda  = fwd_sel(ex_hit_a, mem_hit_a);
    fwdb  = fwd_sel(ex_hit_b, mem_hit_b);
    if (ex_ent.m2reg && (ex_hit_a || ex_hit_b)) wpcir = 1'b1;
  end
`else
  always_comb begin
    wpcir = 1'b0;
    fwda  = FWD_RF;
    fwdb  = FWD_RF;
    if (ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b) wpcir = 1'b1;
  end
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wpcir && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow whichever build (PIPE_HAZARD_FWD_EN) is compiled.
module tb_pipe_hazard_ctrl;

  localparam int NB = 5;
  localparam int CW = 2;

  logic          clock;
  logic          resetn;
  logic [NB-1:0] rs, rt, drn;
  logic          use_rs, use_rt, dwreg, dm2reg;
  logic          wpcir;
  logic [1:0]    fwda, fwdb;
  logic [CW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.NREG_BITS(NB), .CNT_W(CW)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .rs        (rs),
    .rt        (rt),
    .use_rs    (use_rs),
    .use_rt    (use_rt),
    .drn       (drn),
    .dwreg     (dwreg),
    .dm2reg    (dm2reg),
    .wpcir     (wpcir),
    .fwda      (fwda),
    .fwdb      (fwdb),
    .stall_cnt (stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the ID-stage instruction, then let combinational outputs settle.
  task automatic set_id(input logic [NB-1:0] a, input logic ua, input logic [NB-1:0] b,
                        input logic ub, input logic [NB-1:0] d, input logic w, input logic m);
    rs = a; use_rs = ua; rt = b; use_rt = ub; drn = d; dwreg = w; dm2reg = m;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #2;
    check("rst_wpcir", 32'(wpcir), 32'd0);
    check("rst_fwda", 32'(fwda), 32'd0);
    check("rst_fwdb", 32'(fwdb), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    next_cycle();

`ifdef PIPE_HAZARD_FWD_EN
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);        // add r3
    next_cycle();
    set_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);        // reads r3 from EX
    check("ex_fwda", 32'(fwda), 32'd1);
    check("ex_nostall", 32'(wpcir), 32'd0);
    next_cycle();
    set_id(5'd3, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1);        // load r4, reads rt=r3 from MEM
    check("mem_fwdb", 32'(fwdb), 32'd2);
    check("unused_rs", 32'(fwda), 32'd0);
    next_cycle();
    set_id(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);        // load-use on r4
    check("lu_stall", 32'(wpcir), 32'd1);
    next_cycle();
    check("lu_release", 32'(wpcir), 32'd0);
    check("lu_fwda", 32'(fwda), 32'd3);
    check("lu_cnt", 32'(stall_cnt), 32'd1);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);        // writes r0
    next_cycle();
    set_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);        // reads r0, writes r7
    check("r0_stall", 32'(wpcir), 32'd0);
    check("r0_fwda", 32'(fwda), 32'd0);
    next_cycle();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);        // writes r7 again
    next_cycle();
    set_id(5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);        // EX and MEM both hold r7
    check("prio_fwda", 32'(fwda), 32'd1);
    check("prio_fwdb", 32'(fwdb), 32'd1);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);        // load r5
    next_cycle();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);        // load r5 again
    next_cycle();
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("b2b_stall", 32'(wpcir), 32'd1);
    next_cycle();
    check("b2b_release", 32'(wpcir), 32'd0);
    check("b2b_fwda", 32'(fwda), 32'd3);
    check("b2b_cnt", 32'(stall_cnt), 32'd2);
`else
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);        // add r2
    check("idle_stall", 32'(wpcir), 32'd0);
    next_cycle();
    set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);        // reads r2, writes r9
    check("ex_stall", 32'(wpcir), 32'd1);
    check("ex_fwda", 32'(fwda), 32'd0);
    next_cycle();
    check("mem_stall", 32'(wpcir), 32'd1);
    check("mem_fwda", 32'(fwda), 32'd0);
    check("mem_cnt", 32'(stall_cnt), 32'd1);
    next_cycle();
    check("wb_nostall", 32'(wpcir), 32'd0);
    check("two_cnt", 32'(stall_cnt), 32'd2);
    next_cycle();
    set_id(5'd0, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);        // rt=r9 not used
    check("unused_rt", 32'(wpcir), 32'd0);
    set_id(5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);        // rt=r9 used
    check("rt_stall", 32'(wpcir), 32'd1);
    check("rt_fwdb", 32'(fwdb), 32'd0);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);        // writes r0
    next_cycle();
    set_id(5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);        // reads r0
    check("r0_stall", 32'(wpcir), 32'd0);
    check("r0_fwda", 32'(fwda), 32'd0);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);        // load r4
    next_cycle();
    set_id(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("ld_stall", 32'(wpcir), 32'd1);
    #1 resetn = 1'b0;                                        // reset during the stall
    #1;
    check("midrst_stall", 32'(wpcir), 32'd0);
    check("midrst_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    next_cycle();
    check("postrst_stall", 32'(wpcir), 32'd0);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);        // add r6
    next_cycle();
    set_id(5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);        // reads and rewrites r6
    next_cycle();
    next_cycle();
    check("sat_pre_cnt", 32'(stall_cnt), 32'd2);
    check("sat_pre_stall", 32'(wpcir), 32'd0);
    next_cycle();
    check("sat_stall", 32'(wpcir), 32'd1);
    next_cycle();
    check("sat_cnt3", 32'(stall_cnt), 32'd3);
    next_cycle();
    check("sat_hold", 32'(stall_cnt), 32'd3);
    check("sat_release", 32'(wpcir), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

ID-stage hazard controller for the five-stage pipeline. Tracks the destination register of every instruction in flight in EX, MEM and WB, and drives the `wpcir` stall into the PC and IF/ID pipeline registers (1 = hold). It also produces operand-forwarding selects for the ID-stage operand muxes and inserts a bubble into EX whenever it stalls. It is the consumer-side counterpart of the IF/ID register: that register obeys `wpcir`, this block generates it.

## Interface
Parameters:
- `NREG_BITS`, default 5: register-number width.
- `CNT_W`, default 32: stall-counter width.

Ports:
- `clock`  in  1: single clock, rising edge.
- `resetn`  in  1: asynchronous active-low reset.
- `rs`  in  NREG_BITS: ID source register A.
- `rt`  in  NREG_BITS: ID source register B.
- `use_rs`  in  1: ID instruction reads `rs`.
- `use_rt`  in  1: ID instruction reads `rt`.
- `drn`  in  NREG_BITS: ID destination register.
- `dwreg`  in  1: ID instruction writes the register file.
- `dm2reg`  in  1: ID instruction is a load.
- `wpcir`  out  1: stall; 1 holds PC and IF/ID.
- `fwda`  out  2: forward select for A. 00 = regfile, 01 = EX ALU, 10 = MEM ALU, 11 = MEM load data.
- `fwdb`  out  2: forward select for B, same encoding as `fwda`.
- `stall_cnt`  out  CNT_W: cycles with `wpcir` = 1.

## Operation
- Internal tracker holds (rn, wreg, m2reg) for EX, MEM and WB. It shifts every cycle: EX<-ID, MEM<-EX, WB<-MEM.
- When `wpcir` = 1, EX receives a bubble (wreg = 0, m2reg = 0, rn = 0). MEM and WB still shift.
- A register is a hazard source only if its number is nonzero and the in-flight wreg = 1. Register 0 never hazards or forwards.
- Forwarding, evaluated independently for A (`rs`, `use_rs`) and B (`rt`, `use_rt`):
  - EX match with EX m2reg = 0 gives 01.
  - Otherwise, a MEM match gives 10 if MEM m2reg = 0, or 11 if MEM m2reg = 1.
  - Otherwise 00.
  - EX has priority over MEM, so the youngest producer wins.
  - A WB match gives 00: the register file is write-first within the cycle.
- Stall (load-use): `wpcir` = 1 iff EX m2reg = 1 and EX matches a used source. The stall always lasts one cycle, because the load moves to MEM next cycle and then forwards 11.
- If `use_rs` = 0 or `use_rt` = 0, that operand causes neither a stall nor a forward (select 00).
- `stall_cnt` increments on each rising edge where `wpcir` = 1 and saturates at all-ones.

## Timing
- `wpcir`, `fwda` and `fwdb` are combinational from the ID inputs and the tracker state, valid in the same cycle.
- The tracker and `stall_cnt` update on the rising `clock` edge.
- On `resetn` = 0, asynchronously:
  - All tracker entries go to wreg = 0, m2reg = 0, rn = 0, and `stall_cnt` goes to 0.
  - As a result `wpcir` = 0 and `fwda` = `fwdb` = 00, whatever the ID inputs are.
- Reset asserted mid-stall clears the pending load. The first post-reset cycle has no hazard.
- Back-to-back loads to the same register: the second load's consumer stalls exactly one cycle relative to the second load.
- Simultaneous EX and MEM matches on the same register select EX.
- Latency from load issue to consumer issue is 1 stall cycle with forwarding compiled in.

## Configuration
- Macro `PIPE_HAZARD_FWD_EN`.
- Defined: forwarding behaves as described above.
  - `fwda` and `fwdb` follow the selection rules.
  - Stall only on load-use.
- Undefined: `fwda` = `fwdb` = 00 always.
  - `wpcir` = 1 whenever a used source matches EX or MEM, whether or not that entry is a load.
  - A dependent instruction therefore stalls up to 2 cycles, and the bubbles advance through the tracker.
- `stall_cnt` behaves identically in both builds.

## Structure
- Shared package `pipe_pkg` holds:
  - forward-select constants `FWD_RF`, `FWD_EALU`, `FWD_MALU`, `FWD_MMEM`;
  - the typedef for a tracker entry (rn, wreg, m2reg).
- One sub-module, `pipe_dest_track`: the 3-entry shift tracker with bubble insert and asynchronous clear.
- The top level holds the compare/priority logic and the stall counter.

## Test plan
- Reset with `rs` = 5, `use_rs` = 1 -> `wpcir` = 0, `fwda` = 00, `stall_cnt` = 0.
- ALU write to r3, then a consumer reading r3 in the next cycle -> `fwda` = 01, `wpcir` = 0. One cycle later, a consumer with `rt` = 3 -> `fwdb` = 10.
- Load to r4, then a consumer reading r4 as `rs` -> `wpcir` = 1 for exactly 1 cycle. Next cycle `fwda` = 11, and `stall_cnt` = 1.
- Write to r0, then a consumer reading r0 -> no stall, `fwda` = 00.
- EX and MEM both write r7, consumer reads r7 -> `fwda` = 01.
- Without `PIPE_HAZARD_FWD_EN`: ALU write to r2, then an immediate consumer of r2 -> `wpcir` = 1 for 2 cycles, `stall_cnt` = 2, `fwda` = 00 throughout.
